regbank_wr_arbiter: RTL

//  Shares the single scalar write port of the 16x32 register bank (we3/wa3/wd3) between NREQ

---
 rtl/regbank_pkg.sv | 14 +
 rtl/regbank_wr_arbiter_rr.sv | 33 +++
 rtl/regbank_wr_arbiter.sv | 111 +++++++++++
 3 files changed

// File: rtl/regbank_pkg.sv
// Shared register-bank constants and types for the writeback path.
// Imported by the write-port arbiter and its round-robin scanner.
package regbank_pkg;

    localparam int REG_ADDR_W = 4;
    localparam int REG_DATA_W = 32;
    localparam int NUM_REGS   = 16;

    localparam logic [REG_ADDR_W-1:0] REG_VGA = 4'hF;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [REG_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/regbank_wr_arbiter_rr.sv
// Combinational round-robin scanner: starting at ptr, the first set req wins.
// Ports: req (requests), ptr (start index), en (0 = no grant), grant (one-hot), gidx.
module rr_arbiter
    import regbank_pkg::*;
#(
    parameter  int N  = 3,
    localparam int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] gidx
);

    always_comb begin : scan
        int   idx;
        logic found;
        grant = '0;
        gidx  = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (en && !found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                gidx       = PW'(idx);
            end
        end
    end

endmodule

// File: rtl/regbank_wr_arbiter.sv
// Shares the single register-bank write port among NREQ writeback requesters.
// Ports: clk/rst, stall, req_valid/addr/data in, req_ready out, registered
// we3/wa3/wd3 write port, pend_mask (in-flight write), conflicts counter.
module regbank_wr_arbiter
    import regbank_pkg::*;
#(
    parameter int NREQ   = 3,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int DATA_W = REG_DATA_W,
    parameter int CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    input  logic [NREQ*DATA_W-1:0] req_data,
    output logic [NREQ-1:0]        req_ready,
    output logic                   we3,
    output logic [ADDR_W-1:0]      wa3,
    output logic [DATA_W-1:0]      wd3,
    output logic [2**ADDR_W-1:0]   pend_mask,
    output logic [CNT_W-1:0]       conflicts
);

    localparam int PW = $clog2(NREQ);
    localparam int CW = $clog2(NREQ + 1);

    logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
    logic              we3_q, we3_d;
    logic [ADDR_W-1:0] wa3_q, wa3_d;
    logic [DATA_W-1:0] wd3_q, wd3_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [NREQ-1:0] grant;
    logic [PW-1:0]   gidx;
    logic            arb_en;
    logic            gnt_any;
    logic [CW-1:0]   nvalid;

    assign arb_en = !rst && !stall;

    rr_arbiter #(.N(NREQ)) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .en    (arb_en),
        .grant (grant),
        .gidx  (gidx)
    );

    assign req_ready = grant;
    assign gnt_any   = |grant;

    always_comb begin
        nvalid = '0;
        for (int i = 0; i < NREQ; i++) begin
            nvalid = nvalid + CW'(req_valid[i]);
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        we3_d    = gnt_any;
        wa3_d    = wa3_q;
        wd3_d    = wd3_q;
        cnt_d    = cnt_q;
        if (gnt_any) begin
            if (int'(gidx) == NREQ - 1) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = gidx + 1'b1;
            end
            wa3_d = req_addr[gidx*ADDR_W +: ADDR_W];
            wd3_d = req_data[gidx*DATA_W +: DATA_W];
        end
        // Counts even under stall; sticks at all-ones.
        if (nvalid > CW'(1) && !(&cnt_q)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
            we3_q    <= 1'b0;
            wa3_q    <= '0;
            wd3_q    <= '0;
            cnt_q    <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            we3_q    <= we3_d;
            wa3_q    <= wa3_d;
            wd3_q    <= wd3_d;
            cnt_q    <= cnt_d;
        end
    end

    // A register is pending while its granted write sits in the output stage.
    always_comb begin
        pend_mask = '0;
        if (we3_q) begin
            pend_mask[wa3_q] = 1'b1;
        end
    end

    assign we3       = we3_q;
    assign wa3       = wa3_q;
    assign wd3       = wd3_q;
    assign conflicts = cnt_q;

endmodule
